vtg_pattern_gen: RTL and testbench

VTG_PATTERN_GEN -- requirements
Module: vtg_pattern_gen

---
 rtl/vtg_pkg.sv | 38 +++
 rtl/vtg_pattern.sv | 66 ++++++
 rtl/vtg_pattern_gen.sv | 138 +++++++++++++
 tb/tb_vtg_pattern_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vtg_pkg.sv
// rtl/vtg_pkg.sv - shared mode encoding and colour-bar constants for the video timing generator
// Holds the pattern mode enum, the eight 24-bit bar colours (8 bits per
// component, rescaled to COLOR_W where they are used) and a bar lookup helper.
package vtg_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_CHECKER  = 2'd3
    } vtg_mode_e;

    localparam logic [23:0] BAR_WHITE   = 24'hFF_FF_FF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFF_FF_00;
    localparam logic [23:0] BAR_CYAN    = 24'h00_FF_FF;
    localparam logic [23:0] BAR_GREEN   = 24'h00_FF_00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF_00_FF;
    localparam logic [23:0] BAR_RED     = 24'hFF_00_00;
    localparam logic [23:0] BAR_BLUE    = 24'h00_00_FF;
    localparam logic [23:0] BAR_BLACK   = 24'h00_00_00;

    // Bar 0 is the leftmost bar.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vtg_pattern.sv
// rtl/vtg_pattern.sv - combinational test-pattern colour selection from the raster position
// Ports: h_cnt/v_cnt raster position, mode pattern select (already frame-sampled),
// solid_rgb colour for solid mode, rgb selected pixel colour {R,G,B}.
// Optional VTG_BORDER_EN: forces the outermost active rows/columns to white.
module vtg_pattern
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int COLOR_W  = 8,
    parameter int HW       = 11,
    parameter int VW       = 10
) (
    input  logic [HW-1:0]        h_cnt,
    input  logic [VW-1:0]        v_cnt,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [3*COLOR_W-1:0] rgb
);

    localparam int BAR_W = H_ACTIVE / 8;

    int          h_int;
    int          v_int;
    logic [2:0]  bar_idx;
    logic [23:0] pat24;

    assign h_int = int'(h_cnt);
    assign v_int = int'(v_cnt);

    // Left-align an 8-bit component into COLOR_W bits: pads LSBs with zeros
    // for wide components, drops LSBs for narrow ones.
    function automatic logic [COLOR_W-1:0] scale8(input logic [7:0] c);
        return COLOR_W'({c, 4'h0} >> (12 - COLOR_W));
    endfunction

    always_comb begin
        // Pixels past the eighth bar boundary stay on the last (black) bar.
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h_int >= i * BAR_W) begin
                bar_idx = 3'(i);
            end
        end

        case (vtg_mode_e'(mode))
            MODE_BARS:     pat24 = bar_color(bar_idx);
            MODE_GRADIENT: pat24 = {3{8'(h_int)}};
            MODE_CHECKER:  pat24 = (((h_int ^ v_int) & 32) != 0) ? 24'hFF_FF_FF : 24'h0;
            default:       pat24 = 24'h0;
        endcase

        if (vtg_mode_e'(mode) == MODE_SOLID) begin
            rgb = solid_rgb;
        end else begin
            rgb = {scale8(pat24[23:16]), scale8(pat24[15:8]), scale8(pat24[7:0])};
        end

`ifdef VTG_BORDER_EN
        if (h_int == 0 || h_int == H_ACTIVE - 1 || v_int == 0 || v_int == V_ACTIVE - 1) begin
            rgb = '1;
        end
`endif
    end

endmodule

// File: rtl/vtg_pattern_gen.sv
// rtl/vtg_pattern_gen.sv - video timing generator with built-in test patterns
// Ports: pixel_clk, sys_rst_n (async active-low), pll_locked (async lock input),
// mode (0 solid, 1 bars, 2 gradient, 3 checker), solid_rgb; outputs rgb {R,G,B},
// hs, vs, de and frame_start, all registered one cycle after the raster counters.
// Optional macro VTG_BORDER_EN (in vtg_pattern) adds a white border overlay.
module vtg_pattern_gen
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int COLOR_W  = 8
) (
    input  logic                 pixel_clk,
    input  logic                 sys_rst_n,
    input  logic                 pll_locked,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic [3*COLOR_W-1:0] rgb,
    output logic                 hs,
    output logic                 vs,
    output logic                 de,
    output logic                 frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic                 lock_meta;
    logic                 lock_sync;
    logic                 display_en;
    logic [HW-1:0]        h_cnt;
    logic [VW-1:0]        v_cnt;
    logic [1:0]           mode_q;
    logic [3*COLOR_W-1:0] solid_q;

    logic                 at_origin;
    logic                 active;
    logic                 hs_on;
    logic                 vs_on;
    logic [1:0]           mode_use;
    logic [3*COLOR_W-1:0] solid_use;
    logic [3*COLOR_W-1:0] pat_rgb;

    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign active    = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    assign hs_on     = (int'(h_cnt) >= HS_START) && (int'(h_cnt) < HS_END);
    assign vs_on     = (int'(v_cnt) >= VS_START) && (int'(v_cnt) < VS_END);

    // The first pixel of a frame already uses the freshly sampled selection,
    // so a whole frame is always rendered with one mode and one colour.
    assign mode_use  = at_origin ? mode : mode_q;
    assign solid_use = at_origin ? solid_rgb : solid_q;

    vtg_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .COLOR_W  (COLOR_W),
        .HW       (HW),
        .VW       (VW)
    ) u_pattern (
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .mode      (mode_use),
        .solid_rgb (solid_use),
        .rgb       (pat_rgb)
    );

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lock_meta   <= 1'b0;
            lock_sync   <= 1'b0;
            display_en  <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            mode_q      <= 2'd0;
            solid_q     <= '0;
            rgb         <= '0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
        end else begin
            lock_meta  <= pll_locked;
            lock_sync  <= lock_meta;
            display_en <= lock_sync;

            // Holding the counters at zero while disabled guarantees every
            // relock restarts at the top-left of a fresh frame.
            if (!display_en) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (int'(h_cnt) == H_TOTAL - 1) begin
                h_cnt <= '0;
                if (int'(v_cnt) == V_TOTAL - 1) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + VW'(1);
                end
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end

            if (at_origin) begin
                mode_q  <= mode;
                solid_q <= solid_rgb;
            end

            if (display_en) begin
                de          <= active;
                rgb         <= active ? pat_rgb : '0;
                hs          <= hs_on ? HS_POL : ~HS_POL;
                vs          <= vs_on ? VS_POL : ~VS_POL;
                frame_start <= at_origin;
            end else begin
                de          <= 1'b0;
                rgb         <= '0;
                hs          <= ~HS_POL;
                vs          <= ~VS_POL;
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vtg_pattern_gen.sv
// tb/tb_vtg_pattern_gen.sv - self-checking bench for vtg_pattern_gen on a reduced raster
module tb_vtg_pattern_gen;

    localparam int HA = 84, HFP = 4, HSY = 6, HBP = 10;
    localparam int VA = 40, VFP = 2, VSY = 3, VBP = 5;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam bit HSP = 1'b1;
    localparam bit VSP = 1'b0;

    localparam logic [23:0] BAR_TBL [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        pixel_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        pll_locked = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic [23:0] rgb;
    logic        hs, vs, de, frame_start;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    vtg_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
        .HS_POL (HSP), .VS_POL (VSP), .COLOR_W (8)
    ) dut (
        .pixel_clk   (pixel_clk),
        .sys_rst_n   (sys_rst_n),
        .pll_locked  (pll_locked),
        .mode        (mode),
        .solid_rgb   (solid_rgb),
        .rgb         (rgb),
        .hs          (hs),
        .vs          (vs),
        .de          (de),
        .frame_start (frame_start)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge pixel_clk);
            #1;
        end
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!frame_start && n < 6000);
        chk("wait_frame_start", frame_start, 1);
    endtask

    // Reference pixel colour from the pattern rules, 8 bits per component.
    function automatic logic [23:0] model_pixel(input int h, input int v,
                                                input logic [1:0] m, input logic [23:0] s);
        logic [23:0] c;
        int idx;
        case (m)
            2'd0: c = s;
            2'd1: begin
                idx = h / (HA / 8);
                if (idx > 7) idx = 7;
                c = BAR_TBL[idx];
            end
            2'd2: c = {3{8'(h % 256)}};
            default: c = ((((h / 32) % 2) ^ ((v / 32) % 2)) != 0) ? 24'hFFFFFF : 24'h0;
        endcase
`ifdef VTG_BORDER_EN
        if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) c = 24'hFFFFFF;
`endif
        return c;
    endfunction

    // Model: output after edge n is live iff pll_locked was sampled high at
    // edge n-3; live outputs walk the raster from (0,0) one pixel per clock.
    logic [2:0]  m_hist = 3'b0;
    int          m_pos = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [23:0] m_solid = 24'h0;
    logic        m_valid;
    int          m_h, m_v;
    logic [23:0] e_rgb;
    logic        e_de, e_hs, e_vs, e_fs;

    always @(posedge pixel_clk) begin
        if (!sys_rst_n) begin
            m_hist  = 3'b0;
            m_valid = 1'b0;
        end else begin
            m_valid = m_hist[2];
            m_hist  = {m_hist[1:0], pll_locked};
        end
        if (m_valid) begin
            m_h = m_pos % HT;
            m_v = (m_pos / HT) % VT;
            m_pos++;
            if (m_h == 0 && m_v == 0) begin
                m_mode  = mode;
                m_solid = solid_rgb;
            end
            e_de  = (m_h < HA) && (m_v < VA);
            e_hs  = (m_h >= HA + HFP && m_h < HA + HFP + HSY) ? HSP : ~HSP;
            e_vs  = (m_v >= VA + VFP && m_v < VA + VFP + VSY) ? VSP : ~VSP;
            e_fs  = (m_h == 0 && m_v == 0);
            e_rgb = e_de ? model_pixel(m_h, m_v, m_mode, m_solid) : 24'h0;
        end else begin
            m_pos = 0;
            m_h   = -1;
            m_v   = -1;
            e_de  = 1'b0;
            e_hs  = ~HSP;
            e_vs  = ~VSP;
            e_fs  = 1'b0;
            e_rgb = 24'h0;
        end
        #1;
        if (chk_en) begin
            n_assert++;
            if (rgb !== e_rgb || de !== e_de || hs !== e_hs || vs !== e_vs || frame_start !== e_fs) begin
                n_fail++;
                $display("FAIL cycle_model h=%0d v=%0d: got rgb=%h de=%b hs=%b vs=%b fs=%b, expected rgb=%h de=%b hs=%b vs=%b fs=%b",
                         m_h, m_v, rgb, de, hs, vs, frame_start, e_rgb, e_de, e_hs, e_vs, e_fs);
                if (n_fail > 200) summary();
            end
        end
    end

    initial begin
        int de_c, de_l0, hs_c, vs_c, hs_r, fs_c, first_de_l1, n;
        logic prev_hs;

        solid_rgb = 24'h123456;
        #2 sys_rst_n = 1'b0;
        chk_en = 1'b1;
        step(3);
        chk("reset_rgb", rgb, 0);
        chk("reset_de", de, 0);
        chk("reset_fs", frame_start, 0);
        chk("reset_hs", hs, 0);
        chk("reset_vs", vs, 1);

        sys_rst_n = 1'b1;
        step(2);
        pll_locked = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step(1);
            chk("startup_de_low", de, 0);
            chk("startup_hs_idle", hs, 0);
            chk("startup_vs_idle", vs, 1);
        end
        step(1);
        chk("startup_de_edge4", de, 1);
        chk("startup_fs_edge4", frame_start, 1);
        chk("startup_solid_px", rgb, 24'h123456);

        // One whole frame of timing measurements, starting at pixel (0,0).
        de_c = 0; de_l0 = 0; hs_c = 0; vs_c = 0; hs_r = 0; fs_c = 0; first_de_l1 = -1;
        prev_hs = hs;
        for (int i = 0; i < HT * VT; i++) begin
            if (i > 0) step(1);
            de_c += int'(de);
            if (i < HT) de_l0 += int'(de);
            hs_c += int'(hs == 1'b1);
            vs_c += int'(vs == 1'b0);
            if (hs && !prev_hs) hs_r++;
            prev_hs = hs;
            fs_c += int'(frame_start);
            if (i >= HA && de && first_de_l1 < 0) first_de_l1 = i;
        end
        chk("de_per_frame", de_c, 3360);
        chk("de_line0", de_l0, 84);
        chk("line_period", first_de_l1, 104);
        chk("hs_active_clocks", hs_c, 300);
        chk("hs_pulses", hs_r, 50);
        chk("vs_active_clocks", vs_c, 312);
        chk("fs_per_frame", fs_c, 1);
        step(1);
        chk("frame_period", frame_start, 1);

        // Colour bars; last bar plus remainder are black.
        mode = 2'd1;
        wait_fs();
        chk("bars_px0", rgb, 24'hFFFFFF);
        step(10);
        chk("bars_px10", rgb, 24'hFFFF00);
        step(55);
        chk("bars_px65", rgb, 24'h0000FF);
        step(18);
        chk("bars_px83", rgb, 24'h000000);
        chk("bars_px83_de", de, 1);
        step(1);
        chk("bars_px84_de", de, 0);

        mode = 2'd2;
        wait_fs();
        step(5);
        chk("grad_px5", rgb, 24'h050505);
        step(78);
        chk("grad_px83", rgb, 24'h535353);

        // Mode change mid-frame must not take effect until the next frame.
        mode = 2'd0;
        solid_rgb = 24'h123456;
        wait_fs();
        step(HT * 10 + 5);
        mode = 2'd3;
        solid_rgb = 24'h000000;
        step(HT * 10);
        chk("midframe_still_solid", rgb, 24'h123456);
        wait_fs();
        chk("checker_px0_0", rgb, 24'h000000);
        step(32);
        chk("checker_px32_0", rgb, 24'hFFFFFF);

        // Lock loss at line 30, then relock.
        step(30 * HT - 32);
        chk("pre_drop_de", de, 1);
        pll_locked = 1'b0;
        step(4);
        chk("drop_de", de, 0);
        chk("drop_rgb", rgb, 0);
        step(3);
        chk("drop_hs_idle", hs, 0);
        chk("drop_vs_idle", vs, 1);
        pll_locked = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!de && n < 20);
        chk("relock_de", de, 1);
        chk("relock_fs", frame_start, 1);
        chk("relock_latency", n, 4);
        step(32);
        chk("relock_checker_px32", rgb, 24'hFFFFFF);

`ifdef VTG_BORDER_EN
        mode = 2'd0;
        solid_rgb = 24'h0;
        wait_fs();
        chk("border_px0_0", rgb, 24'hFFFFFF);
        step(HT + 1);
        chk("border_px1_1", rgb, 24'h000000);
        step(82);
        chk("border_px83_1", rgb, 24'hFFFFFF);
        step(39 * HT + 5 - (HT + 83));
        chk("border_px5_39", rgb, 24'hFFFFFF);
`endif

        step(HT);
        summary();
    end

endmodule
